// File: rtl/mul_bcd_pkg.sv
// Shared types and constants for the signed multiply / BCD display sequencer.
// The BCD_LEADING_BLANK_EN macro is consumed by bcd_window_sel, not by this package.
package mul_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        BCD  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int BCD_DIGITS = 5;
    localparam int WIN_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    localparam logic [3:0] BLANK_CODE    = 4'hF;
    localparam logic [3:0] DABBLE_ADD    = 4'd3;
    localparam logic [3:0] DABBLE_THRESH = 4'd5;

    // Pre-shift correction of one double-dabble step: every digit >= 5 gets +3.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] >= DABBLE_THRESH) begin
                r[4*i +: 4] = v[4*i +: 4] + DABBLE_ADD;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_window_sel.sv
// Combinational 4-of-5 digit rotation window over the held BCD result.
// Optional macro BCD_LEADING_BLANK_EN replaces leading-zero digits (never d0) with the blank code.
module bcd_window_sel
    import mul_bcd_pkg::*;
(
    input  logic [BCD_W-1:0]        bcd,
    input  logic [2:0]              pos,
    output logic [4*WIN_DIGITS-1:0] window
);

`ifdef BCD_LEADING_BLANK_EN
    logic [BCD_DIGITS-1:0] lead_zero;

    // A digit is leading-zero when it and every digit above it are zero.
    always_comb begin
        lead_zero = '0;
        lead_zero[BCD_DIGITS-1] = (bcd[4*(BCD_DIGITS-1) +: 4] == 4'd0);
        for (int i = BCD_DIGITS - 2; i >= 1; i--) begin
            lead_zero[i] = lead_zero[i+1] & (bcd[4*i +: 4] == 4'd0);
        end
        lead_zero[0] = 1'b0;
    end
`endif

    always_comb begin
        logic [3:0] idx;
        window = '0;
        idx    = '0;
        for (int j = 0; j < WIN_DIGITS; j++) begin
            idx = {1'b0, pos} + 4'(j);
            if (idx >= 4'(BCD_DIGITS)) idx = idx - 4'(BCD_DIGITS);
            if (idx >= 4'(BCD_DIGITS)) idx = 4'd0;
`ifdef BCD_LEADING_BLANK_EN
            window[4*j +: 4] = lead_zero[idx[2:0]] ? BLANK_CODE : bcd[4*int'(idx) +: 4];
`else
            window[4*j +: 4] = bcd[4*int'(idx) +: 4];
`endif
        end
    end

endmodule

// File: rtl/mul_bcd_sequencer.sv
// Signed shift-add multiplier followed by bit-serial double-dabble into a held 5-digit BCD result.
// Display window scrolls mod 5; BCD_LEADING_BLANK_EN (in bcd_window_sel) enables leading-zero blanking.
module mul_bcd_sequencer
    import mul_bcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             scroll_left,
    input  logic             scroll_right,
    output logic             busy,
    output logic             done,
    output logic             negative,
    output logic [19:0]      bcd,
    output logic [15:0]      window,
    output logic [2:0]       window_pos
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int CNT_W  = $clog2(PROD_W) + 1;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) without overflow.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               sign_q, sign_d;
    logic [PROD_W-1:0]  acc_q, acc_d;
    logic [PROD_W-1:0]  prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   dd_q, dd_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic [2:0]         pos_q, pos_d;
    logic               load;
    logic [BCD_W-1:0]   dd_adj;
    logic [PROD_W-1:0]  mcand_ext;

    assign dd_adj    = dabble_adjust(dd_q);
    assign mcand_ext = {{(PROD_W-WIDTH){1'b0}}, mcand_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            acc_q    <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            dd_q     <= '0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            dd_q     <= dd_d;
            bcd_q    <= bcd_d;
            neg_q    <= neg_d;
            pos_q    <= pos_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        dd_d     = dd_q;
        bcd_d    = bcd_q;
        neg_d    = neg_q;
        load     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = magnitude(multiplicand);
                    mplier_d = magnitude(multiplier);
                    sign_d   = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? (mcand_ext << cnt_q) : '0);
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    prod_d  = acc_d;
                    dd_d    = '0;
                    cnt_d   = '0;
                    state_d = BCD;
                end
            end
            BCD: begin
                // Product is fed MSB first; acc_q keeps the full product for the zero test.
                dd_d   = {dd_adj[BCD_W-2:0], prod_q[PROD_W-1]};
                prod_d = prod_q << 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PROD_W - 1)) begin
                    bcd_d   = dd_d;
                    neg_d   = sign_q & (acc_q != '0);
                    load    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Loading a fresh result recentres the window and wins over any scroll that cycle.
    always_comb begin
        pos_d = pos_q;
        if (load) begin
            pos_d = '0;
        end else if (scroll_left && !scroll_right) begin
            pos_d = (pos_q >= 3'd4) ? 3'd0 : pos_q + 3'd1;
        end else if (scroll_right && !scroll_left) begin
            pos_d = (pos_q == 3'd0) ? 3'd4 : pos_q - 3'd1;
        end
    end

    bcd_window_sel u_window_sel (
        .bcd    (bcd_q),
        .pos    (pos_q),
        .window (window)
    );

    assign busy       = (state_q == MUL) || (state_q == BCD);
    assign done       = (state_q == DONE);
    assign negative   = neg_q;
    assign bcd        = bcd_q;
    assign window_pos = pos_q;

endmodule

// File: doc/mul_bcd_sequencer.md
Name: mul_bcd_sequencer

Overview:
Sequential controller that accepts two signed operands and sequences a shift-add multiply over operand magnitudes. It then runs a bit-serial double-dabble conversion of the product into 5 BCD digits and holds the result with a sign flag for display. It owns a wrap-around 4-digit display window over the 5 held digits, replacing the free-running scroll register on the display path.

Parameters:
WIDTH, 8, operand width in bits; supported range 2..8 (product ≤ 16384 fits 5 BCD digits); PROD_W = 2*WIDTH derived internally.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request new operation; sampled only in IDLE
multiplicand  in  WIDTH  signed two's-complement operand A
multiplier  in  WIDTH  signed two's-complement operand B
scroll_left  in  1  single-cycle pulse, window position +1 mod 5
scroll_right  in  1  single-cycle pulse, window position -1 mod 5
busy  out  1  high in MUL and BCD states
done  out  1  one-cycle pulse when new result is valid
negative  out  1  sign of held result
bcd  out  20  held result, digit i = bcd[4i+3:4i]
window  out  16  4 visible digits
window_pos  out  3  current window position, 0..4

Behaviour:
- Reset (synchronous, any state, including mid-operation): state=IDLE; busy=0, done=0, negative=0, bcd=0, window_pos=0. The in-flight result is discarded.
- FSM states: IDLE, MUL, BCD, DONE.
  - IDLE: stays in IDLE unless start=1. On start=1, at that edge (edge k):
    - latch |A| and |B| as WIDTH-bit unsigned magnitudes (-2^(WIDTH-1) maps to 2^(WIDTH-1), no overflow);
    - latch sign = A[msb] ^ B[msb];
    - clear the accumulator and counter;
    - go to MUL.
  - MUL: one shift-add iteration per cycle for WIDTH cycles (edges k+1..k+WIDTH). Accumulator is PROD_W bits. Go to BCD after the last iteration.
  - BCD: one double-dabble step per cycle for PROD_W cycles.
    - Each step: add 3 to every nibble ≥5, then shift left with the next product bit (MSB first).
    - At the final step, load bcd and negative, and go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency, WIDTH=8: start sampled at edge k; bcd/negative update and done rises at edge k+24; done falls at edge k+25. start is accepted again from edge k+25.
- start while busy or in DONE is ignored; there is no queueing.
- Operands are sampled only at the accepting edge; later operand changes have no effect.
- negative = sign & (product != 0), so zero is always positive.
- bcd/negative hold their previous values through MUL and BCD; the display does not flicker.
- Window selection (combinational from bcd and window_pos):
  - window = {d[(p+3)%5], d[(p+2)%5], d[(p+1)%5], d[p]}.
  - p=0 gives {d3,d2,d1,d0}.
- Scroll, registered, accepted in any state:
  - scroll_left alone: p ← (p+1) mod 5, so 4 wraps to 0.
  - scroll_right alone: p ← (p+4) mod 5, so 0 wraps to 4.
  - both high in the same cycle: no change.
  - the edge that loads a new result forces p ← 0 and overrides any scroll in that cycle.

Optional Feature:
Macro: BCD_LEADING_BLANK_EN.
- Defined: window digits holding leading zeros of bcd are output as 4'hF (blank code).
  - Leading zeros are those above the most significant nonzero digit, evaluated on the 5-digit value before rotation.
  - d0 is never blanked, so result 0 shows digit 0.
  - bcd output itself is unaffected.
- Not defined: window shows raw digits, including 0s; no blanking logic is synthesized.

Decomposition:
- Package mul_bcd_pkg:
  - state enum {IDLE, MUL, BCD, DONE};
  - BCD_DIGITS=5, WIN_DIGITS=4, BLANK_CODE=4'hF;
  - DABBLE_ADD=4'd3, DABBLE_THRESH=4'd5.
- One sub-module: bcd_window_sel, purely combinational. Inputs bcd[19:0] and pos[2:0]; output window[15:0]. It contains the rotation mux and, under the macro, the leading-blank logic.
- The FSM, datapath and scroll register live in the top module.

Test Plan:
- Reset, then start with A=8'hF9 (-7), B=8'd12 → busy=1 from the next cycle; done pulses 24 edges after the start edge; bcd=20'h00084, negative=1, window=16'h0084, window_pos=0.
- A=8'h80 (-128), B=8'h80 (-128) → bcd=20'h16384, negative=0.
- A=8'h00, B=8'hFB (-5) → bcd=0, negative=0.
- After the 16384 result: scroll_left ×2 → window_pos=2, window=16'h4163; then scroll_right ×3 → window_pos=4, window=16'h3841; scroll_left and scroll_right together → unchanged.
- Start (A=3, B=4); at the 5th MUL cycle pulse start again, then assert rst for 1 cycle → the second start is ignored; after rst: busy=0, done never pulses, bcd=0, negative=0, window_pos=0.
- With BCD_LEADING_BLANK_EN defined, -7×12 at pos 0 → window=16'hFF84. Result 0 → window=16'hFFF0. Without the macro, the same cases give 16'h0084 and 16'h0000.
